lj_frame_sequencer: RTL

- Front-end controller for the left-justified audio conversion path, clocked by the serial bit clock.
- Measures BCK cycles per LRCK half-frame, classifies the slot width as 16, 24 or 32, and locks after a programmable number of consistent frames.
- Sequences the downstream 32LJ-to-16LJ converter: one reset pulse on lock, mute control while unlocked, and a bit-in-slot index.
- Counts lock-loss events for status readout.

---
 rtl/lj_frame_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lj_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lj_frame_sequencer
// Brief    : Measures LRCK half-frames in BCK cycles, locks onto a 16/24/32
//            slot width and sequences the downstream 32LJ-to-16LJ converter.
// Revision : 1.0 - initial release
// ============================================================================
module lj_frame_sequencer #(
    parameter int LOCK_FRAMES = 4,
    parameter int MUTE_HOLD   = 2,
    parameter int CNT_W       = 7
) (
    input  logic             bck,
    input  logic             rst,
    input  logic             en,
    input  logic             lrck,
    output logic [CNT_W-1:0] slot_len,
    output logic [1:0]       fmt,
    output logic             locked,
    output logic             mute,
    output logic             conv_rst,
    output logic [4:0]       bit_idx,
    output logic [7:0]       err_cnt
);

    localparam int c_match_w = $clog2(2*LOCK_FRAMES + 1);
    localparam int c_hold_w  = $clog2(2*MUTE_HOLD + 2);

    localparam logic [c_match_w-1:0] c_match_goal = c_match_w'(2*LOCK_FRAMES);
    localparam logic [c_hold_w-1:0]  c_hold_goal  = c_hold_w'(2*MUTE_HOLD);
    localparam logic [CNT_W:0]       c_len16      = (CNT_W+1)'(16);
    localparam logic [CNT_W:0]       c_len24      = (CNT_W+1)'(24);
    localparam logic [CNT_W:0]       c_len32      = (CNT_W+1)'(32);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_search  = 3'd1;
    localparam logic [2:0] c_st_measure = 3'd2;
    localparam logic [2:0] c_st_verify  = 3'd3;
    localparam logic [2:0] c_st_locked  = 3'd4;

    logic [2:0]           r_state;
    logic                 r_lrck_d;
    logic [CNT_W-1:0]     r_cnt;
    logic [c_match_w-1:0] r_match;
    logic [1:0]           r_cand;
    logic [c_hold_w-1:0]  r_hold;

    logic                 w_edge;
    logic                 w_cnt_max;
    logic [CNT_W:0]       w_len;
    logic [CNT_W-1:0]     w_slot;
    logic [1:0]           w_class;
    logic                 w_valid;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [4:0]           w_bit_next;
    logic [c_match_w-1:0] w_match_inc;
    logic [c_hold_w-1:0]  w_hold_inc;

    always_comb begin
        w_edge    = (lrck != r_lrck_d);
        w_cnt_max = (r_cnt == {CNT_W{1'b1}});
        // One extra bit so a saturated counter does not alias onto a valid length
        w_len     = {1'b0, r_cnt} + (CNT_W+1)'(1);
        w_slot    = w_len[CNT_W] ? {CNT_W{1'b1}} : w_len[CNT_W-1:0];
        case (w_len)
            c_len16: w_class = 2'b01;
            c_len24: w_class = 2'b10;
            c_len32: w_class = 2'b11;
            default: w_class = 2'b00;
        endcase
        w_valid     = (w_class != 2'b00);
        w_cnt_next  = w_edge ? '0 : (w_cnt_max ? r_cnt : r_cnt + CNT_W'(1));
        w_bit_next  = (w_cnt_next > CNT_W'(31)) ? 5'd31 : 5'(w_cnt_next);
        w_match_inc = r_match + c_match_w'(1);
        w_hold_inc  = r_hold + c_hold_w'(1);
    end

    always_ff @(posedge bck) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_lrck_d <= 1'b0;
            r_cnt    <= '0;
            r_match  <= '0;
            r_cand   <= 2'b00;
            r_hold   <= '0;
            slot_len <= '0;
            fmt      <= 2'b00;
            locked   <= 1'b0;
            mute     <= 1'b1;
            conv_rst <= 1'b0;
            bit_idx  <= 5'd0;
            err_cnt  <= 8'd0;
        end else begin
            // Edge detection and length measurement run regardless of state
            r_lrck_d <= lrck;
            r_cnt    <= w_cnt_next;
            conv_rst <= 1'b0;
            if (w_edge) begin
                slot_len <= w_slot;
            end

            if (!en) begin
                r_state <= c_st_idle;
                fmt     <= 2'b00;
                locked  <= 1'b0;
                r_match <= '0;
                r_hold  <= '0;
                bit_idx <= 5'd0;
                mute    <= 1'b1;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_state <= c_st_search;
                    end
                    c_st_search: begin
                        if (w_edge) begin
                            r_state <= c_st_measure;
                        end
                    end
                    c_st_measure: begin
                        if (w_edge && w_valid) begin
                            r_state <= c_st_verify;
                            r_cand  <= w_class;
                            r_match <= c_match_w'(1);
                        end
                    end
                    c_st_verify: begin
                        if (w_edge) begin
                            if (!w_valid) begin
                                r_state <= c_st_measure;
                            end else if (w_class != r_cand) begin
                                r_cand  <= w_class;
                                r_match <= c_match_w'(1);
                            end else if (w_match_inc == c_match_goal) begin
                                r_state  <= c_st_locked;
                                r_match  <= w_match_inc;
                                fmt      <= r_cand;
                                locked   <= 1'b1;
                                r_hold   <= '0;
                                conv_rst <= 1'b1;
                                bit_idx  <= 5'd0;
                            end else begin
                                r_match <= w_match_inc;
                            end
                        end else if (w_cnt_max) begin
                            r_state <= c_st_measure;
                        end
                    end
                    c_st_locked: begin
                        if (w_edge && (w_class == fmt)) begin
                            if (r_hold != c_hold_goal) begin
                                r_hold <= w_hold_inc;
                            end
                            if (w_hold_inc >= c_hold_goal) begin
                                mute <= 1'b0;
                            end
                            bit_idx <= w_bit_next;
                        end else if (w_edge || w_cnt_max) begin
                            // Mismatching half or lost LRCK: count it and drop lock
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            locked  <= 1'b0;
                            fmt     <= 2'b00;
                            mute    <= 1'b1;
                            bit_idx <= 5'd0;
                            if (w_edge && w_valid) begin
                                r_state <= c_st_verify;
                                r_cand  <= w_class;
                                r_match <= c_match_w'(1);
                            end else begin
                                r_state <= c_st_measure;
                            end
                        end else begin
                            bit_idx <= w_bit_next;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
